vga_sync_decoder: RTL and testbench

- Receive-side counterpart of the VGA timing generator: recovers pixel coordinates, active-video enable and frame markers from a raw hsync/vsync/RGB stream.
- Verifies line and frame timing, reports lock and error counts.
- Sits at the input of capture/overlay paths (test loopback of the display chain, LCD re-timing, video checkers) on the 25 MHz pixel clock.

---
 rtl/vga_sync_decoder.sv | 185 ++++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing recovery: rebuilds pixel coordinates, active-video enable and
// frame markers from a raw hsync/vsync/RGB stream, and tracks lock and timing errors.
module vga_sync_decoder #(
  parameter int   WIDTH       = 640,
  parameter int   HEIGHT      = 480,
  parameter int   H_SYNC      = 96,
  parameter int   H_BP        = 48,
  parameter int   H_TOTAL     = 800,
  parameter int   V_SYNC      = 2,
  parameter int   V_BP        = 33,
  parameter int   V_TOTAL     = 525,
  parameter logic SYNC_ACT    = 1'b0,
  parameter int   LOCK_FRAMES = 2
) (
  input  logic       clk_25,
  input  logic       resetN,
  input  logic       h_sync,
  input  logic       v_sync,
  input  logic [3:0] red_in,
  input  logic [3:0] green_in,
  input  logic [3:0] blue_in,
  output logic [9:0] pxl_x,
  output logic [9:0] pxl_y,
  output logic       en,
  output logic       frame_start,
  output logic       locked,
  output logic [7:0] err_cnt,
  output logic [3:0] red_out,
  output logic [3:0] green_out,
  output logic [3:0] blue_out
);

  localparam int          H_START   = H_SYNC + H_BP;
  localparam int          V_START   = V_SYNC + V_BP;
  localparam logic [9:0]  H_OFF     = 10'(H_START);
  localparam logic [9:0]  V_OFF     = 10'(V_START);
  localparam logic [10:0] H_BEG_W   = 11'(H_START);
  localparam logic [10:0] H_END_W   = 11'(H_START + WIDTH);
  localparam logic [10:0] V_BEG_W   = 11'(V_START);
  localparam logic [10:0] V_END_W   = 11'(V_START + HEIGHT);
  localparam logic [10:0] H_TOTAL_W = 11'(H_TOTAL);
  localparam logic [10:0] V_TOTAL_W = 11'(V_TOTAL);
  localparam logic [3:0]  LOCK_W    = 4'(LOCK_FRAMES);
  localparam logic [9:0]  CNT_MAX   = '1;

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_CHECK  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  logic        hs_q, vs_q;
  logic [11:0] rgb_q;
  logic [9:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d, lcnt_q, lcnt_d;
  logic        vs_pend_q, vs_pend_d, line_seen_q;
  logic [1:0]  state_q, state_d;
  logic [3:0]  good_q, good_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic [9:0]  pxl_x_q, pxl_y_q;
  logic        en_q, en_d, fs_q, fs_d;
  logic [11:0] rgb_out_q, rgb_out_d;

  logic        hs_edge, vs_edge, line_err, frame_err, any_err, in_window;
  logic [10:0] frame_lines;

  // An edge is a fresh assertion: previous sample idle, current raw input asserted.
  assign hs_edge = (hs_q != SYNC_ACT) && (h_sync == SYNC_ACT);
  assign vs_edge = (vs_q != SYNC_ACT) && (v_sync == SYNC_ACT);

  // Line count at a vsync edge includes a coincident hsync edge, so vsync phase within a line does not matter.
  assign frame_lines = {1'b0, lcnt_q} + {10'd0, hs_edge};
  assign line_err    = hs_edge && line_seen_q && (({1'b0, h_cnt_q} + 11'd1) != H_TOTAL_W);
  assign frame_err   = vs_edge && (state_q != ST_SEARCH) && (frame_lines != V_TOTAL_W);
  assign any_err     = line_err || frame_err;

  assign in_window = ({1'b0, h_cnt_q} >= H_BEG_W) && ({1'b0, h_cnt_q} < H_END_W) &&
                     ({1'b0, v_cnt_q} >= V_BEG_W) && ({1'b0, v_cnt_q} < V_END_W);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    vs_pend_d = vs_pend_q;
    lcnt_d    = lcnt_q;

    if (hs_edge) h_cnt_d = '0;
    else if (h_cnt_q != CNT_MAX) h_cnt_d = h_cnt_q + 10'd1;

    if (hs_edge) begin
      if (vs_edge || vs_pend_q) begin
        v_cnt_d   = '0;
        vs_pend_d = 1'b0;
      end else if (v_cnt_q != CNT_MAX) begin
        v_cnt_d = v_cnt_q + 10'd1;
      end
    end else if (vs_edge) begin
      vs_pend_d = 1'b1;
    end

    if (vs_edge) lcnt_d = '0;
    else if (hs_edge && (lcnt_q != CNT_MAX)) lcnt_d = lcnt_q + 10'd1;
  end

  // An error in the same cycle as a vsync edge takes priority over any state advance.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    unique case (state_q)
      ST_SEARCH: begin
        if (vs_edge && !line_err) begin
          state_d = ST_CHECK;
          good_d  = '0;
        end
      end
      ST_CHECK: begin
        if (any_err) begin
          state_d = ST_SEARCH;
        end else if (vs_edge) begin
          good_d = good_q + 4'd1;
          if ((good_q + 4'd1) >= LOCK_W) state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (any_err) state_d = ST_SEARCH;
      end
      default: state_d = ST_SEARCH;
    endcase
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (any_err && (state_q != ST_SEARCH) && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
    fs_d      = vs_edge && (state_q == ST_LOCKED) && !any_err;
    en_d      = in_window && (state_q == ST_LOCKED);
    rgb_out_d = en_d ? rgb_q : 12'd0;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_25 or negedge resetN) begin
    if (!resetN) begin
      hs_q        <= ~SYNC_ACT;
      vs_q        <= ~SYNC_ACT;
      rgb_q       <= '0;
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      lcnt_q      <= '0;
      vs_pend_q   <= 1'b0;
      line_seen_q <= 1'b0;
      state_q     <= ST_SEARCH;
      good_q      <= '0;
      err_cnt_q   <= '0;
      pxl_x_q     <= '0;
      pxl_y_q     <= '0;
      en_q        <= 1'b0;
      fs_q        <= 1'b0;
      rgb_out_q   <= '0;
    end else begin
      hs_q        <= h_sync;
      vs_q        <= v_sync;
      rgb_q       <= {red_in, green_in, blue_in};
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      lcnt_q      <= lcnt_d;
      vs_pend_q   <= vs_pend_d;
      line_seen_q <= line_seen_q | hs_edge;
      state_q     <= state_d;
      good_q      <= good_d;
      err_cnt_q   <= err_cnt_d;
      pxl_x_q     <= h_cnt_q - H_OFF;
      pxl_y_q     <= v_cnt_q - V_OFF;
      en_q        <= en_d;
      fs_q        <= fs_d;
      rgb_out_q   <= rgb_out_d;
    end
  end

  assign pxl_x       = pxl_x_q;
  assign pxl_y       = pxl_y_q;
  assign en          = en_q;
  assign frame_start = fs_q;
  assign locked      = (state_q == ST_LOCKED);
  assign err_cnt     = err_cnt_q;
  assign red_out     = rgb_out_q[11:8];
  assign green_out   = rgb_out_q[7:4];
  assign blue_out    = rgb_out_q[3:0];

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder on a scaled 16x12 timing; a second instance with inverted
// sync polarity sees the same stream and must behave identically.
module tb_vga_sync_decoder;

  localparam int WIDTH = 8, HEIGHT = 4, H_SYNC = 3, H_BP = 2, H_TOTAL = 16;
  localparam int V_SYNC = 2, V_BP = 3, V_TOTAL = 12, LOCK_FRAMES = 2;

  logic       clk_25 = 1'b0;
  logic       resetN = 1'b1;
  logic       h_sync = 1'b1, v_sync = 1'b1;
  logic       h_sync_n, v_sync_n;
  logic [3:0] red_in = '0, green_in = '0, blue_in = '0;

  logic [9:0] a_pxl_x, a_pxl_y, b_pxl_x, b_pxl_y;
  logic       a_en, a_fs, a_locked, b_en, b_fs, b_locked;
  logic [7:0] a_err, b_err;
  logic [3:0] a_red, a_green, a_blue, b_red, b_green, b_blue;

  assign h_sync_n = ~h_sync;
  assign v_sync_n = ~v_sync;

  always #5 clk_25 = ~clk_25;

  vga_sync_decoder #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .H_SYNC(H_SYNC), .H_BP(H_BP), .H_TOTAL(H_TOTAL),
    .V_SYNC(V_SYNC), .V_BP(V_BP), .V_TOTAL(V_TOTAL), .SYNC_ACT(1'b0), .LOCK_FRAMES(LOCK_FRAMES)
  ) dut_a (
    .clk_25(clk_25), .resetN(resetN), .h_sync(h_sync), .v_sync(v_sync),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .pxl_x(a_pxl_x), .pxl_y(a_pxl_y), .en(a_en), .frame_start(a_fs), .locked(a_locked),
    .err_cnt(a_err), .red_out(a_red), .green_out(a_green), .blue_out(a_blue)
  );

  vga_sync_decoder #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .H_SYNC(H_SYNC), .H_BP(H_BP), .H_TOTAL(H_TOTAL),
    .V_SYNC(V_SYNC), .V_BP(V_BP), .V_TOTAL(V_TOTAL), .SYNC_ACT(1'b1), .LOCK_FRAMES(LOCK_FRAMES)
  ) dut_b (
    .clk_25(clk_25), .resetN(resetN), .h_sync(h_sync_n), .v_sync(v_sync_n),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .pxl_x(b_pxl_x), .pxl_y(b_pxl_y), .en(b_en), .frame_start(b_fs), .locked(b_locked),
    .err_cnt(b_err), .red_out(b_red), .green_out(b_green), .blue_out(b_blue)
  );

  // Position fields give the pixel whose outputs are visible; -1 in any expectation means "don't care".
  typedef struct {
    int f, l, c;
    int en, x, y, red;
    int lk, fs, err;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0, n_fail = 0;
  int   gf, gl, gc, p1f, p1l, p1c, p2f, p2l, p2c, obs_f, obs_l, obs_c;
  int   short_f = -1, short_l = -1, shortframe_f = -1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check2(input string name, input int act_a, input int act_b, input int exp);
    check({name, " (active-low)"}, act_a, exp);
    check({name, " (active-high)"}, act_b, exp);
  endtask

  function automatic void add(int f, int l, int c, int en, int x, int y, int red,
                              int lk, int fs, int err);
    vec_t v;
    v = '{f, l, c, en, x, y, red, lk, fs, err};
    tbl.push_back(v);
  endfunction

  task automatic drive(input bit hs_a, input bit vs_a, input logic [3:0] r, g, b);
    @(posedge clk_25);
    #1;
    h_sync   = hs_a ? 1'b0 : 1'b1;
    v_sync   = vs_a ? 1'b0 : 1'b1;
    red_in   = r;
    green_in = g;
    blue_in  = b;
    @(negedge clk_25);
  endtask

  task automatic restart_stream();
    gf = 0; gl = 0; gc = 0;
    p1f = -1; p1l = -1; p1c = -1;
    p2f = -1; p2l = -1; p2c = -1;
  endtask

  // One pixel of the generated stream; outputs seen afterwards belong to the pixel two steps back.
  task automatic stream_step();
    int len, lines;
    obs_f = p2f; obs_l = p2l; obs_c = p2c;
    p2f = p1f; p2l = p1l; p2c = p1c;
    p1f = gf; p1l = gl; p1c = gc;
    drive(gc < H_SYNC, gl < V_SYNC, 4'(gc), 4'(gl), 4'(15 - gc));
    len   = (gf == short_f && gl == short_l) ? H_TOTAL - 1 : H_TOTAL;
    lines = (gf == shortframe_f) ? V_TOTAL - 1 : V_TOTAL;
    gc++;
    if (gc == len) begin
      gc = 0;
      gl++;
      if (gl == lines) begin
        gl = 0;
        gf++;
      end
    end
  endtask

  task automatic run_until(input int f, input int l, input int c, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      stream_step();
      if (obs_f == f && obs_l == l && obs_c == c) ok = 1'b1;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL reach: got f%0d l%0d c%0d, expected f%0d l%0d c%0d within 1000 cycles",
               obs_f, obs_l, obs_c, f, l, c);
    end
  endtask

  task automatic apply_table();
    bit    ok;
    string tag;
    for (int i = 0; i < tbl.size(); i++) begin
      run_until(tbl[i].f, tbl[i].l, tbl[i].c, ok);
      if (ok) begin
        tag = $sformatf("f%0d l%0d c%0d", tbl[i].f, tbl[i].l, tbl[i].c);
        if (tbl[i].en >= 0) begin
          check2({tag, " en"}, a_en, b_en, tbl[i].en);
          check2({tag, " red"}, a_red, b_red, tbl[i].red);
          check2({tag, " green"}, a_green, b_green, tbl[i].en == 1 ? (tbl[i].l % 16) : 0);
          check2({tag, " blue"}, a_blue, b_blue, tbl[i].en == 1 ? 15 - (tbl[i].c % 16) : 0);
        end
        if (tbl[i].x >= 0) begin
          check2({tag, " pxl_x"}, a_pxl_x, b_pxl_x, tbl[i].x);
          check2({tag, " pxl_y"}, a_pxl_y, b_pxl_y, tbl[i].y);
        end
        if (tbl[i].lk >= 0)  check2({tag, " locked"}, a_locked, b_locked, tbl[i].lk);
        if (tbl[i].fs >= 0)  check2({tag, " frame_start"}, a_fs, b_fs, tbl[i].fs);
        if (tbl[i].err >= 0) check2({tag, " err_cnt"}, a_err, b_err, tbl[i].err);
      end
    end
    tbl.delete();
  endtask

  task automatic check_zero(input string tag);
    check2({tag, " pxl_x"}, a_pxl_x, b_pxl_x, 0);
    check2({tag, " pxl_y"}, a_pxl_y, b_pxl_y, 0);
    check2({tag, " en"}, a_en, b_en, 0);
    check2({tag, " frame_start"}, a_fs, b_fs, 0);
    check2({tag, " locked"}, a_locked, b_locked, 0);
    check2({tag, " err_cnt"}, a_err, b_err, 0);
    check2({tag, " rgb"}, {a_red, a_green, a_blue}, {b_red, b_green, b_blue}, 0);
  endtask

  task automatic reset_dut();
    resetN = 1'b0;
    h_sync = 1'b1; v_sync = 1'b1;
    red_in = '0; green_in = '0; blue_in = '0;
    repeat (2) @(negedge clk_25);
    resetN = 1'b1;
  endtask

  initial begin
    bit ok;
    #1 resetN = 1'b0;
    #2 check_zero("reset");
    reset_dut();

    // Nominal stream: lock at the third vsync edge, window x 5..12, y 5..8.
    restart_stream();
    //   f  l   c  en  x   y  red  lk  fs  err
    add(0,  0,  1,  0, -1, -1,  0,  0,  0,  0);
    add(1, 11, 14, -1, -1, -1, -1,  0, -1, -1);
    add(1, 11, 15, -1, -1, -1, -1,  1,  0,  0);
    add(2,  4, 12,  0, -1, -1,  0,  1, -1, -1);
    add(2,  5,  4,  0, -1, -1,  0, -1, -1, -1);
    add(2,  5,  5,  1,  0,  0,  5,  1,  0,  0);
    add(2,  8, 12,  1,  7,  3, 12, -1, -1, -1);
    add(2,  8, 13,  0, -1, -1,  0, -1, -1, -1);
    add(2,  9,  5,  0, -1, -1,  0, -1, -1, -1);
    add(2, 11, 15, -1, -1, -1, -1,  1,  1,  0);
    add(3,  0,  0, -1, -1, -1, -1,  1,  0,  0);
    add(3,  6, 10,  1,  5,  1, 10, -1, -1, -1);
    apply_table();

    // One 15-clock line while locked, then relock three vsync edges later.
    short_f = 4; short_l = 6;
    add(4,  6, 12,  1,  7,  1, 12,  1, -1,  0);
    add(4,  6, 13,  0, -1, -1,  0,  1, -1,  0);
    add(4,  6, 14, -1, -1, -1, -1,  0,  0,  1);
    add(4,  7,  5,  0, -1, -1,  0,  0, -1,  1);
    add(4, 11, 15, -1, -1, -1, -1,  0,  0,  1);
    add(6, 11, 14, -1, -1, -1, -1,  0, -1,  1);
    add(6, 11, 15, -1, -1, -1, -1,  1,  0,  1);
    add(7,  5,  5,  1,  0,  0,  5,  1, -1,  1);
    add(7, 11, 15, -1, -1, -1, -1,  1,  1,  1);
    add(8,  6,  8,  1,  3,  1,  8,  1, -1,  1);
    apply_table();

    // Reset in the middle of an active line clears outputs without waiting for a clock.
    #2 resetN = 1'b0;
    #1 check_zero("midline reset");
    reset_dut();

    // 11-line frame while in CHECK: error, then relock needs 1 + LOCK_FRAMES vsync edges.
    short_f = -1; short_l = -1; shortframe_f = 1;
    restart_stream();
    add(1, 10, 14, -1, -1, -1, -1,  0, -1,  0);
    add(1, 10, 15, -1, -1, -1, -1,  0,  0,  1);
    add(2,  5,  5,  0, -1, -1,  0,  0, -1,  1);
    add(3, 11, 15, -1, -1, -1, -1,  0, -1,  1);
    add(4, 11, 15, -1, -1, -1, -1,  1,  0,  1);
    add(5,  5,  5,  1,  0,  0,  5,  1, -1,  1);
    apply_table();

    // Repeated enter-CHECK / bad-line cycles drive the error counter into saturation.
    reset_dut();
    drive(1'b1, 1'b0, '0, '0, '0);
    repeat (3) drive(1'b0, 1'b0, '0, '0, '0);
    for (int i = 1; i <= 300; i++) begin
      drive(1'b0, 1'b1, '0, '0, '0);
      drive(1'b0, 1'b0, '0, '0, '0);
      drive(1'b1, 1'b0, '0, '0, '0);
      drive(1'b0, 1'b0, '0, '0, '0);
      drive(1'b0, 1'b0, '0, '0, '0);
      if (i == 1 || i == 254 || i == 255 || i == 256 || i == 300)
        check2($sformatf("saturate iter %0d err_cnt", i), a_err, b_err, (i < 255) ? i : 255);
    end
    check2("saturate locked", a_locked, b_locked, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
